// File: rtl/fifo_ctrl_ram_8x12.sv
// FIFO controller for an external 8x12 single-clock RAM: pointers, occupancy,
// threshold flags and a sticky error state machine driving the RAM port.
module fifo_ctrl_ram_8x12 #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] addr_wa,
    output logic [ADDR_WIDTH-1:0] addr_ra,
    output logic                  we_a,
    output logic                  re_a,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3,
        ST_ERROR  = 4'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [ADDR_WIDTH-1:0] thr_hi_reg, thr_hi_next;
    logic [ADDR_WIDTH-1:0] thr_lo_reg, thr_lo_next;
    logic                  full_reg, full_next;
    logic                  empty_reg, empty_next;
    logic                  afull_reg, afull_next;
    logic                  aempty_reg, aempty_next;
    logic                  error_reg, error_next;
    logic                  valid_reg;

    logic running;
    logic wr_ok, rd_ok, overflow, underflow;

    assign running   = (state_reg == ST_IDLE) || (state_reg == ST_ACTIVE);
    assign wr_ok     = running && push && (!full_reg || pop);
    assign rd_ok     = (state_reg == ST_ACTIVE) && pop && !empty_reg;
    assign overflow  = running && push && full_reg && !pop;
    assign underflow = running && pop && empty_reg;

    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg + {{(ADDR_WIDTH-1){1'b0}}, wr_ok};
        rd_ptr_next = rd_ptr_reg + {{(ADDR_WIDTH-1){1'b0}}, rd_ok};
        count_next  = count_reg + {{ADDR_WIDTH{1'b0}}, wr_ok}
                                - {{ADDR_WIDTH{1'b0}}, rd_ok};
        error_next  = error_reg || overflow || underflow;
        thr_hi_next = thr_hi_reg;
        thr_lo_next = thr_lo_reg;

        if (state_reg == ST_INIT) begin
            thr_hi_next = umbral_alto;
            thr_lo_next = umbral_bajo;
        end

        case (state_reg)
            ST_RESET: state_next = ST_INIT;
            ST_INIT:  state_next = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (overflow || underflow)
                    state_next = ST_ERROR;
                else if (count_next == '0)
                    state_next = ST_IDLE;
                else
                    state_next = ST_ACTIVE;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RESET;
        endcase

        // init wins over everything, including a same-cycle overflow/underflow
        if (init && (state_reg != ST_RESET)) begin
            state_next  = ST_INIT;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            error_next  = 1'b0;
        end

        // Flags are registered from the post-edge count and thresholds
        full_next   = (count_next == FULL_COUNT);
        empty_next  = (count_next == '0);
        afull_next  = !full_next  && (count_next >= {1'b0, thr_hi_next});
        aempty_next = !empty_next && (count_next <= {1'b0, thr_lo_next});
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg  <= ST_RESET;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            thr_hi_reg <= '0;
            thr_lo_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b0;
            error_reg  <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            thr_hi_reg <= thr_hi_next;
            thr_lo_reg <= thr_lo_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            afull_reg  <= afull_next;
            aempty_reg <= aempty_next;
            error_reg  <= error_next;
            valid_reg  <= rd_ok;
        end
    end

    assign data_a       = data_in;
    assign addr_wa      = wr_ptr_reg;
    assign addr_ra      = rd_ptr_reg;
    assign we_a         = wr_ok;
    assign re_a         = rd_ok;
    assign data_out     = q_a;
    assign valid_out    = valid_reg;
    assign fifo_count   = count_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = afull_reg;
    assign almost_empty = aempty_reg;
    assign error        = error_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_fifo_ctrl_ram_8x12.sv
// Bench for fifo_ctrl_ram_8x12: directed table, corner sequences and random
// traffic against a queue-based FIFO reference model with an attached RAM.
module tb_fifo_ctrl_ram_8x12;

    localparam int DW = 12;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          init = 1'b0;
    logic [AW-1:0] umbral_alto = '0;
    logic [AW-1:0] umbral_bajo = '0;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] q_a;
    logic [DW-1:0] data_a;
    logic [AW-1:0] addr_wa, addr_ra;
    logic          we_a, re_a;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   fifo_count;
    logic          full, empty, almost_full, almost_empty, error;
    logic [3:0]    state;

    always #5 clk = ~clk;

    fifo_ctrl_ram_8x12 dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .push(push), .data_in(data_in), .pop(pop), .q_a(q_a),
        .data_a(data_a), .addr_wa(addr_wa), .addr_ra(addr_ra),
        .we_a(we_a), .re_a(re_a), .data_out(data_out), .valid_out(valid_out),
        .fifo_count(fifo_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error), .state(state)
    );

    // The RAM the controller drives: write and registered read on the same edge
    logic [DW-1:0] mem [0:7];
    always @(posedge clk) begin
        if (we_a) mem[addr_wa] <= data_a;
        if (re_a) q_a <= mem[addr_ra];
    end

    localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

    int            m_state;
    logic [DW-1:0] m_q[$];
    int            m_wp, m_rp, m_hi, m_lo;
    bit            m_err, m_valid;
    logic [DW-1:0] m_dout;
    logic [AW-1:0] set_hi = 3'd6, set_lo = 3'd2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic predict(output bit e_we, output bit e_re, output bit ovf, output bit udf);
        int  cnt;
        bit  run;
        cnt  = m_q.size();
        run  = (m_state == S_IDLE) || (m_state == S_ACTIVE);
        e_we = run && push && (cnt < 8 || pop);
        e_re = (m_state == S_ACTIVE) && pop && (cnt > 0);
        ovf  = run && push && (cnt == 8) && !pop;
        udf  = run && pop && (cnt == 0);
    endtask

    task automatic check_all();
        bit e_we, e_re, ovf, udf;
        int cnt;
        bit e_full, e_empty, e_af, e_ae;
        predict(e_we, e_re, ovf, udf);
        cnt     = m_q.size();
        e_full  = (m_state != S_RESET) && (cnt == 8);
        e_empty = (m_state == S_RESET) || (cnt == 0);
        e_af    = (m_state != S_RESET) && !e_full && (cnt >= m_hi);
        e_ae    = (m_state != S_RESET) && !e_empty && (cnt <= m_lo);
        chk("we_a", we_a, e_we);
        chk("re_a", re_a, e_re);
        chk("addr_wa", addr_wa, m_wp);
        chk("addr_ra", addr_ra, m_rp);
        chk("data_a", data_a, data_in);
        chk("state", state, m_state);
        chk("fifo_count", fifo_count, cnt);
        chk("full", full, e_full);
        chk("empty", empty, e_empty);
        chk("almost_full", almost_full, e_af);
        chk("almost_empty", almost_empty, e_ae);
        chk("error", error, m_err);
        chk("valid_out", valid_out, m_valid);
        if (m_valid) chk("data_out", data_out, m_dout);
    endtask

    task automatic model_update();
        bit e_we, e_re, ovf, udf;
        predict(e_we, e_re, ovf, udf);
        m_valid = e_re;
        if (e_re) begin
            m_dout = m_q.pop_front();
            m_rp   = (m_rp + 1) % 8;
        end
        if (e_we) begin
            m_q.push_back(data_in);
            m_wp = (m_wp + 1) % 8;
        end
        if (m_state == S_INIT) begin
            m_hi = umbral_alto;
            m_lo = umbral_bajo;
        end
        if (m_state == S_RESET) begin
            m_state = S_INIT;
        end else if (init) begin
            m_state = S_INIT;
            m_q.delete();
            m_wp  = 0;
            m_rp  = 0;
            m_err = 0;
        end else if (m_state == S_INIT) begin
            m_state = S_IDLE;
        end else if (m_state == S_IDLE || m_state == S_ACTIVE) begin
            if (ovf || udf) begin
                m_state = S_ERROR;
                m_err   = 1;
            end else begin
                m_state = (m_q.size() == 0) ? S_IDLE : S_ACTIVE;
            end
        end
    endtask

    task automatic step(input bit i_init, input bit i_push, input bit i_pop,
                        input logic [DW-1:0] din);
        @(negedge clk);
        init        = i_init;
        push        = i_push;
        pop         = i_pop;
        data_in     = din;
        umbral_alto = set_hi;
        umbral_bajo = set_lo;
        #1;
        check_all();
        $display("step t=%0t init=%0b push=%0b pop=%0b din=%03h state=%0d count=%0d valid=%0b dout=%03h",
                 $time, i_init, i_push, i_pop, din, state, fifo_count, valid_out, data_out);
        model_update();
    endtask

    // Reset asserted between clock edges so only the async path can clear state
    task automatic do_reset();
        @(negedge clk);
        #2;
        init    = 0;
        push    = 0;
        pop     = 0;
        reset_L = 1'b0;
        m_state = S_RESET;
        m_q.delete();
        m_wp = 0; m_rp = 0; m_hi = 0; m_lo = 0;
        m_err = 0; m_valid = 0;
        #1;
        check_all();
        chk("rst_state", state, 4'd0);
        chk("rst_valid", valid_out, 1'b0);
        $display("reset t=%0t state=%0d error=%0b", $time, state, error);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    typedef struct {
        bit            init, push, pop;
        logic [DW-1:0] din;
        bit            we, re;
        logic [AW-1:0] wa, ra;
        logic [3:0]    st;
        logic [AW:0]   cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 4'd0, 0};
        tbl[1]  = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 4'd1, 0};
        tbl[2]  = '{0, 0, 0, 12'h000, 0, 0, 0, 0, 4'd1, 0};
        tbl[3]  = '{0, 1, 0, 12'hFFF, 1, 0, 0, 0, 4'd2, 0};
        tbl[4]  = '{0, 1, 0, 12'hAAA, 1, 0, 1, 0, 4'd3, 1};
        tbl[5]  = '{0, 1, 0, 12'h555, 1, 0, 2, 0, 4'd3, 2};
        tbl[6]  = '{0, 1, 0, 12'hFC0, 1, 0, 3, 0, 4'd3, 3};
        tbl[7]  = '{0, 0, 1, 12'h000, 0, 1, 4, 0, 4'd3, 4};
        tbl[8]  = '{0, 0, 1, 12'h000, 0, 1, 4, 1, 4'd3, 3};
        tbl[9]  = '{0, 0, 1, 12'h000, 0, 1, 4, 2, 4'd3, 2};
        tbl[10] = '{0, 0, 1, 12'h000, 0, 1, 4, 3, 4'd3, 1};
        tbl[11] = '{0, 0, 0, 12'h000, 0, 0, 4, 4, 4'd2, 0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].init, tbl[i].push, tbl[i].pop, tbl[i].din);
            chk("tbl_we", we_a, tbl[i].we);
            chk("tbl_re", re_a, tbl[i].re);
            chk("tbl_wa", addr_wa, tbl[i].wa);
            chk("tbl_ra", addr_ra, tbl[i].ra);
            chk("tbl_state", state, tbl[i].st);
            chk("tbl_count", fifo_count, tbl[i].cnt);
        end

        // Restart from pointer 0, fill to full, then push+pop while full
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 12'(i));
        step(0, 0, 0, 0);
        chk("fill_full", full, 1'b1);
        chk("fill_count", fifo_count, 4'd8);
        for (int i = 9; i <= 11; i++) begin
            step(0, 1, 1, 12'(i));
            chk("pp_full", full, 1'b1);
            chk("pp_error", error, 1'b0);
        end
        step(0, 0, 0, 0);
        chk("wrap_wa", addr_wa, 3'd3);
        chk("wrap_ra", addr_ra, 3'd3);
        chk("wrap_count", fifo_count, 4'd8);

        // Overflow, recovery via init, underflow, then async reset
        step(0, 1, 0, 12'h0EE);
        chk("ovf_we", we_a, 1'b0);
        step(0, 0, 0, 0);
        chk("ovf_error", error, 1'b1);
        chk("ovf_state", state, 4'd4);
        chk("ovf_count", fifo_count, 4'd8);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("init_state", state, 4'd1);
        chk("init_error", error, 1'b0);
        chk("init_count", fifo_count, 4'd0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("udf_error", error, 1'b1);
        chk("udf_state", state, 4'd4);
        do_reset();

        // Random traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 3000; i++) begin
            bit ri, p, q;
            int pp;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            ri     = (m_state == S_ERROR) || ($urandom_range(0, 59) == 0);
            set_hi = 3'($urandom);
            set_lo = 3'($urandom);
            pp     = ((i / 40) % 2 == 0) ? 70 : 30;
            p      = ($urandom_range(0, 99) < pp);
            q      = ($urandom_range(0, 99) < (100 - pp));
            step(ri, p, q, 12'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
